// File: rtl/ram_port_arbiter.sv
// Arbitrates a single-port RAM between an instruction-fetch port and a load/store data port.
// Define RAM_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests instead of data-first priority.
module ram_port_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
    typedef enum logic {FETCH = 1'b0, DATA = 1'b1} port_t;

    state_t            state, state_n;
    port_t             winner, winner_n;
    logic              we, we_n;
    logic [ADDR_W-1:0] address_n;
    logic [DATA_W-1:0] data_in_n;
    logic [DATA_W-1:0] if_rdata_n, d_rdata_n;
    logic              rd_n, wr_n, if_done_n, d_done_n, busy_n;
    logic              grant_data;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    port_t last_gnt, last_gnt_n;

    // On a tie the port that was not served last wins; a lone requester always wins.
    always_comb begin
        grant_data = d_req;
        if (d_req && if_req) begin
            grant_data = (last_gnt == FETCH);
        end
    end
`else
    always_comb begin
        grant_data = d_req;
    end
`endif

    always_comb begin
        state_n    = state;
        winner_n   = winner;
        we_n       = we;
        address_n  = ram_address;
        data_in_n  = ram_data_in;
        if_rdata_n = if_rdata;
        d_rdata_n  = d_rdata;
        rd_n       = 1'b0;
        wr_n       = 1'b0;
        if_done_n  = 1'b0;
        d_done_n   = 1'b0;
        busy_n     = 1'b1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_gnt_n = last_gnt;
`endif
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (d_req || if_req) begin
                    winner_n  = grant_data ? DATA : FETCH;
                    we_n      = grant_data ? d_we : 1'b0;
                    address_n = grant_data ? d_addr : if_addr;
                    data_in_n = grant_data ? d_wdata : ram_data_in;
                    rd_n      = ~we_n;
                    wr_n      = we_n;
                    busy_n    = 1'b1;
                    state_n   = ACCESS;
                end
            end
            ACCESS: begin
                if (we) begin
                    d_done_n = 1'b1;
                    state_n  = RESP;
                end else begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                // RAM output is registered, so the word is only valid in this cycle.
                if (winner == DATA) begin
                    d_rdata_n = ram_data_out;
                    d_done_n  = 1'b1;
                end else begin
                    if_rdata_n = ram_data_out;
                    if_done_n  = 1'b1;
                end
                state_n = RESP;
            end
            RESP: begin
                busy_n  = 1'b0;
                state_n = IDLE;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                last_gnt_n = winner;
`endif
            end
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            winner      <= FETCH;
            we          <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            ram_rd      <= 1'b0;
            ram_wr      <= 1'b0;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            busy        <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_gnt    <= FETCH;
`endif
        end else begin
            state       <= state_n;
            winner      <= winner_n;
            we          <= we_n;
            ram_address <= address_n;
            ram_data_in <= data_in_n;
            ram_rd      <= rd_n;
            ram_wr      <= wr_n;
            if_done     <= if_done_n;
            d_done      <= d_done_n;
            if_rdata    <= if_rdata_n;
            d_rdata     <= d_rdata_n;
            busy        <= busy_n;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_gnt    <= last_gnt_n;
`endif
        end
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 128x16 RAM between two requesters: the instruction-fetch port (read-only) and the data port (load/store).
- Sits between the CPU control unit and the RAM.
- Owns the RAM address, rd, wr and data_in strobes, and returns read data through registered per-port response paths using a req/done handshake.
- Default policy is fixed priority, with the data port winning.

Parameters:
- ADDR_W, 7, RAM address width (128 words).
- DATA_W, 16, RAM word width; data passes through bit-exact, and signedness is the requester's concern.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- if_req  input  1  fetch request; held high until if_done.
- if_addr  input  ADDR_W  fetch address.
- if_done  output  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  output  DATA_W  fetched word; holds until the next fetch completes.
- d_req  input  1  data request; held high until d_done.
- d_we  input  1  1 = store, 0 = load; qualified by d_req.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_done  output  1  one-cycle pulse: load or store complete.
- d_rdata  output  DATA_W  loaded word; holds until the next load completes.
- ram_address  output  ADDR_W  to RAM address.
- ram_rd  output  1  to RAM rd.
- ram_wr  output  1  to RAM wr.
- ram_data_in  output  DATA_W  to RAM data_in.
- ram_data_out  input  DATA_W  from RAM data_out; registered by the RAM, valid the cycle after rd is sampled.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock is clk. Reset is rst_n: synchronous, active-low.
- Reset values: all outputs 0, state IDLE, last_gnt = FETCH.
- All outputs are registered. RAM contract: strobes are sampled on posedge; read data is valid one cycle after the sampling edge.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - If either req is high, pick a winner.
  - Latch winner id, address, we and wdata into internal registers.
  - Drive ram_address/ram_data_in from the latched values. Set ram_rd = ~we, or ram_wr = we (always rd for fetch).
  - Go to ACCESS. With no request, stay in IDLE and keep strobes 0.
- ACCESS (1 cycle):
  - Strobes are high, so the RAM acts on this cycle's closing edge.
  - At that edge, clear strobes.
  - Write: set the winner's done, go to RESP.
  - Read: go to CAPTURE.
- CAPTURE (1 cycle):
  - ram_data_out is valid.
  - At the edge, load it into the winner's rdata, set the winner's done, go to RESP.
- RESP (1 cycle):
  - Winner's done = 1.
  - At the edge, clear done, update last_gnt to the winner, go to IDLE.
- Latency, counted from the cycle req is first seen in IDLE as cycle 0:
  - read: done high in cycle 3;
  - write: done high in cycle 2.
  - The mandatory IDLE cycle between transactions gives a throughput of 1 read per 4 cycles.
- Handshake:
  - A requester holds req, addr, we and wdata stable until done.
  - It drops req at the edge that ends the done cycle.
  - req high in IDLE always means a new request.
  - Port inputs that change while busy are ignored; the latched copies are used.
- Arbitration: fixed priority, d_req over if_req. A simultaneous request leaves the loser waiting, and it is served in the next IDLE.
- Only one of ram_rd/ram_wr is ever high, and only in ACCESS.
- The non-winning port's done and rdata are untouched.
- Reset mid-operation:
  - Next state is IDLE; strobes, done and busy clear.
  - rdata registers clear to 0.
  - A write whose ACCESS cycle coincides with the reset edge still completes in the RAM, because strobes are already high.
  - No done is issued for an aborted transaction.
- Address wraps naturally at 7 bits; no range checks.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous requests in IDLE, grant the port not equal to last_gnt.
  - last_gnt resets to FETCH, so the first tie goes to the data port.
  - A single requester is always granted regardless of last_gnt.
- Undefined: fixed data-over-fetch priority as above; last_gnt is not implemented.

Test Plan:
- Reset, then fetch if_addr=0 with RAM[0]=16'h1817: ram_rd high in cycle 1 only, if_done in cycle 3, if_rdata=16'h1817, busy high for cycles 1-3.
- Store d_we=1 d_addr=25 d_wdata=16'hFFFB: ram_wr high in cycle 1 with ram_address=25, d_done in cycle 2. Then load addr 25: d_rdata=16'hFFFB, d_done in cycle 3.
- if_req (addr 1) and d_req load (addr 20, RAM=16'h0002) rise in the same cycle: data served first (d_rdata=16'h0002), then fetch. With RAM_ARB_ROUND_ROBIN_EN, two back-to-back ties alternate grants data, fetch, data, fetch.
- Change d_addr from 20 to 21 while the port is busy on a load of 20: returned d_rdata is RAM[20]; RAM address bus never shows 21 during that transaction.
- Assert rst_n=0 during CAPTURE of a fetch: next cycle all outputs 0, state IDLE, no if_done. A fresh fetch afterwards completes normally in 3 cycles.
- Hold both reqs high continuously with correct handshake for 40 cycles: ram_rd and ram_wr are never both high, and every done is exactly one cycle wide.
